mem_port_arbiter: RTL and testbench

//   Shares one single-ported external memory between the core's instruction-fetch and data-access ports.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the core's fetch/data ports, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Core side: a request (inst_ren / mem_ren|mem_wen) is held until its stall drops; the word is
  // valid in the cycle the stall is low. Memory side: ext_req and its address/data stay constant
  // until ext_ack, and ext_rdata is valid only together with ext_ack.
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              inst_stall;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              data_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_ack;
  logic              bus_err;

  modport slave (
    input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, ext_rdata, ext_ack,
    output inst_data, inst_stall, mem_din, data_stall, ext_req, ext_we, ext_addr, ext_wdata,
           bus_err
  );

  modport master (
    output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, ext_rdata, ext_ack,
    input  inst_data, inst_stall, mem_din, data_stall, ext_req, ext_we, ext_addr, ext_wdata,
           bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one memory port, data first, with req/ack handshake.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  if ((1 << CNT_W) <= MAX_WAIT) begin : g_cnt_w_check
    $error("CNT_W too narrow for MAX_WAIT");
  end

  state_e            state_q, state_d;
  logic              ext_we_q, ext_we_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              data_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT - 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;
`endif

  assign data_req = bus.mem_ren | bus.mem_wen;

  always_comb begin
    state_d     = state_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    inst_data_d = inst_data_q;
    mem_din_d   = mem_din_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d     = BUSY_D;
          ext_we_d    = bus.mem_wen;
          ext_addr_d  = bus.mem_addr;
          ext_wdata_d = bus.mem_dout;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (bus.inst_ren) begin
          state_d     = BUSY_I;
          ext_we_d    = 1'b0;
          ext_addr_d  = bus.inst_addr;
          ext_wdata_d = '0;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY_I: begin
        if (bus.ext_ack) begin
          state_d     = RESP_I;
          inst_data_d = bus.ext_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == WAIT_LIMIT) begin
          state_d     = RESP_I;
          inst_data_d = '0;
          bus_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      BUSY_D: begin
        // Writes complete without touching the read-data register.
        if (bus.ext_ack) begin
          state_d = RESP_D;
          if (!ext_we_q) mem_din_d = bus.ext_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == WAIT_LIMIT) begin
          state_d   = RESP_D;
          bus_err_d = 1'b1;
          if (!ext_we_q) mem_din_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      inst_data_q <= inst_data_d;
      mem_din_q   <= mem_din_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  // Stalls stay combinational so the core sees completion in the RESP cycle itself.
  assign bus.inst_stall = ~rst & bus.inst_ren & (state_q != RESP_I);
  assign bus.data_stall = ~rst & data_req & (state_q != RESP_D);
  assign bus.ext_req    = (state_q == BUSY_I) | (state_q == BUSY_D);
  assign bus.ext_we     = ext_we_q;
  assign bus.ext_addr   = ext_addr_q;
  assign bus.ext_wdata  = ext_wdata_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.mem_din    = mem_din_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.bus_err    = bus_err_q;
`else
  assign bus.bus_err    = 1'b0;
`endif
  assign state_o        = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, write, reset mid-access, flush, watchdog.
module tb_mem_port_arbiter;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BUSY_I = 3'd1;
  localparam logic [2:0] S_BUSY_D = 3'd2;
  localparam logic [2:0] S_RESP_I = 3'd3;
  localparam logic [2:0] S_RESP_D = 3'd4;

  logic       clk;
  logic       rst;
  logic [2:0] state;
  int         errors;
  int         checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.inst_ren = 1'b1;
    bus.inst_addr = '0;
    bus.mem_ren = 1'b1;
    bus.mem_wen = 1'b0;
    bus.mem_addr = '0;
    bus.mem_dout = '0;
    bus.ext_rdata = '0;
    bus.ext_ack = 1'b0;

    // Reset: requests present but stalls forced low
    next_cycle();
    next_cycle();
    mid();
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_inst_stall", 32'(bus.inst_stall), 32'd0);
    chk("rst_data_stall", 32'(bus.data_stall), 32'd0);
    chk("rst_ext_req", 32'(bus.ext_req), 32'd0);
    chk("rst_ext_addr", bus.ext_addr, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
    next_cycle();
    rst = 1'b0;
    bus.inst_ren = 1'b0;
    bus.mem_ren = 1'b0;
    mid();
    chk("rst_rel_state", 32'(state), 32'(S_IDLE));

    // 1: fetch only
    next_cycle();
    bus.inst_ren = 1'b1;
    bus.inst_addr = 32'h100;
    mid();
    chk("t1_stall_n", 32'(bus.inst_stall), 32'd1);
    chk("t1_req_n", 32'(bus.ext_req), 32'd0);
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'h2402000A;
    mid();
    chk("t1_state_n1", 32'(state), 32'(S_BUSY_I));
    chk("t1_req_n1", 32'(bus.ext_req), 32'd1);
    chk("t1_addr_n1", bus.ext_addr, 32'h100);
    chk("t1_we_n1", 32'(bus.ext_we), 32'd0);
    chk("t1_stall_n1", 32'(bus.inst_stall), 32'd1);
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t1_state_n2", 32'(state), 32'(S_RESP_I));
    chk("t1_stall_n2", 32'(bus.inst_stall), 32'd0);
    chk("t1_data_n2", bus.inst_data, 32'h2402000A);
    chk("t1_req_n2", 32'(bus.ext_req), 32'd0);
    next_cycle();
    bus.inst_ren = 1'b0;
    mid();
    chk("t1_idle", 32'(state), 32'(S_IDLE));

    // 2: collision, data first
    next_cycle();
    bus.inst_ren = 1'b1;
    bus.inst_addr = 32'h200;
    bus.mem_ren = 1'b1;
    bus.mem_addr = 32'h80;
    mid();
    chk("t2_istall_n", 32'(bus.inst_stall), 32'd1);
    chk("t2_dstall_n", 32'(bus.data_stall), 32'd1);
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'h11112222;
    mid();
    chk("t2_state_n1", 32'(state), 32'(S_BUSY_D));
    chk("t2_addr_n1", bus.ext_addr, 32'h80);
    chk("t2_istall_n1", 32'(bus.inst_stall), 32'd1);
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t2_state_n2", 32'(state), 32'(S_RESP_D));
    chk("t2_dstall_n2", 32'(bus.data_stall), 32'd0);
    chk("t2_din_n2", bus.mem_din, 32'h11112222);
    chk("t2_istall_n2", 32'(bus.inst_stall), 32'd1);
    next_cycle();
    bus.mem_ren = 1'b0;
    mid();
    chk("t2_state_n3", 32'(state), 32'(S_IDLE));
    chk("t2_istall_n3", 32'(bus.inst_stall), 32'd1);
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'h33334444;
    mid();
    chk("t2_state_n4", 32'(state), 32'(S_BUSY_I));
    chk("t2_addr_n4", bus.ext_addr, 32'h200);
    chk("t2_istall_n4", 32'(bus.inst_stall), 32'd1);
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t2_istall_n5", 32'(bus.inst_stall), 32'd0);
    chk("t2_idata_n5", bus.inst_data, 32'h33334444);
    next_cycle();
    bus.inst_ren = 1'b0;

    // 3: write with ack delayed 3 cycles
    next_cycle();
    bus.mem_wen = 1'b1;
    bus.mem_addr = 32'h40;
    bus.mem_dout = 32'hDEADBEEF;
    mid();
    chk("t3_dstall_n", 32'(bus.data_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) begin
        bus.ext_ack = 1'b1;
        bus.ext_rdata = 32'hBAD0BAD0;
      end
      mid();
      chk($sformatf("t3_state_b%0d", i), 32'(state), 32'(S_BUSY_D));
      chk($sformatf("t3_we_b%0d", i), 32'(bus.ext_we), 32'd1);
      chk($sformatf("t3_wdata_b%0d", i), bus.ext_wdata, 32'hDEADBEEF);
      chk($sformatf("t3_addr_b%0d", i), bus.ext_addr, 32'h40);
      chk($sformatf("t3_req_b%0d", i), 32'(bus.ext_req), 32'd1);
    end
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t3_state_resp", 32'(state), 32'(S_RESP_D));
    chk("t3_dstall_resp", 32'(bus.data_stall), 32'd0);
    chk("t3_din_kept", bus.mem_din, 32'h11112222);
    next_cycle();
    bus.mem_wen = 1'b0;

    // 4: reset during BUSY_D, stray ack afterwards
    next_cycle();
    bus.mem_ren = 1'b1;
    bus.mem_addr = 32'h44;
    next_cycle();
    mid();
    chk("t4_state_busy", 32'(state), 32'(S_BUSY_D));
    chk("t4_req_busy", 32'(bus.ext_req), 32'd1);
    next_cycle();
    rst = 1'b1;
    mid();
    chk("t4_dstall_rst", 32'(bus.data_stall), 32'd0);
    next_cycle();
    rst = 1'b0;
    bus.mem_ren = 1'b0;
    mid();
    chk("t4_state_after", 32'(state), 32'(S_IDLE));
    chk("t4_req_after", 32'(bus.ext_req), 32'd0);
    chk("t4_addr_after", bus.ext_addr, 32'd0);
    chk("t4_din_after", bus.mem_din, 32'd0);
    chk("t4_idata_after", bus.inst_data, 32'd0);
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'h55555555;
    mid();
    chk("t4_state_ack", 32'(state), 32'(S_IDLE));
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t4_state_post", 32'(state), 32'(S_IDLE));
    chk("t4_din_post", bus.mem_din, 32'd0);
    chk("t4_req_post", 32'(bus.ext_req), 32'd0);

    // 5: fetch flushed during BUSY_I, then a data read
    next_cycle();
    bus.inst_ren = 1'b1;
    bus.inst_addr = 32'h300;
    next_cycle();
    bus.inst_ren = 1'b0;
    mid();
    chk("t5_state_busy", 32'(state), 32'(S_BUSY_I));
    chk("t5_req_busy", 32'(bus.ext_req), 32'd1);
    chk("t5_istall_flush", 32'(bus.inst_stall), 32'd0);
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'h77778888;
    bus.mem_ren = 1'b1;
    bus.mem_addr = 32'h90;
    mid();
    chk("t5_state_wait", 32'(state), 32'(S_BUSY_I));
    chk("t5_dstall_wait", 32'(bus.data_stall), 32'd1);
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t5_state_resp", 32'(state), 32'(S_RESP_I));
    chk("t5_idata_resp", bus.inst_data, 32'h77778888);
    chk("t5_dstall_resp", 32'(bus.data_stall), 32'd1);
    next_cycle();
    mid();
    chk("t5_state_idle", 32'(state), 32'(S_IDLE));
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'h9999AAAA;
    mid();
    chk("t5_state_grant", 32'(state), 32'(S_BUSY_D));
    chk("t5_addr_grant", bus.ext_addr, 32'h90);
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t5_din_resp", bus.mem_din, 32'h9999AAAA);
    chk("t5_dstall_done", 32'(bus.data_stall), 32'd0);
    next_cycle();
    bus.mem_ren = 1'b0;

    // 6: fetch with no ack
    next_cycle();
    bus.inst_ren = 1'b1;
    bus.inst_addr = 32'h500;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      next_cycle();
      mid();
      chk($sformatf("t6_state_b%0d", i), 32'(state), 32'(S_BUSY_I));
      chk($sformatf("t6_err_b%0d", i), 32'(bus.bus_err), 32'd0);
    end
    next_cycle();
    mid();
    chk("t6_state_abort", 32'(state), 32'(S_RESP_I));
    chk("t6_err_abort", 32'(bus.bus_err), 32'd1);
    chk("t6_idata_abort", bus.inst_data, 32'd0);
    chk("t6_istall_abort", 32'(bus.inst_stall), 32'd0);
    chk("t6_req_abort", 32'(bus.ext_req), 32'd0);
    next_cycle();
    bus.inst_ren = 1'b0;
    mid();
    chk("t6_err_clear", 32'(bus.bus_err), 32'd0);
    chk("t6_state_idle", 32'(state), 32'(S_IDLE));
`else
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      mid();
      chk($sformatf("t6_state_b%0d", i), 32'(state), 32'(S_BUSY_I));
      chk($sformatf("t6_err_b%0d", i), 32'(bus.bus_err), 32'd0);
    end
    next_cycle();
    bus.ext_ack = 1'b1;
    bus.ext_rdata = 32'hCAFEF00D;
    next_cycle();
    bus.ext_ack = 1'b0;
    mid();
    chk("t6_state_resp", 32'(state), 32'(S_RESP_I));
    chk("t6_idata_resp", bus.inst_data, 32'hCAFEF00D);
    chk("t6_err_resp", 32'(bus.bus_err), 32'd0);
    next_cycle();
    bus.inst_ren = 1'b0;
`endif

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
